// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad scanner: FSM states, register map,
// status/control bit positions and the key-code format.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, SCAN, RELEASE} state_t;

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_STATUS = 3'd2;
  localparam logic [2:0] ADDR_CTRL   = 3'd4;

  localparam int STAT_NONEMPTY  = 0;
  localparam int STAT_OVERFLOW  = 1;
  localparam int STAT_IRQ_EN    = 2;
  localparam int STAT_COUNT_LSB = 3;

  localparam int CTRL_FLUSH  = 0;
  localparam int CTRL_IRQ_EN = 1;

  localparam int KEY_INDEX_W = 6;
  localparam int KEY_CODE_W  = 16;

  function automatic logic [KEY_CODE_W-1:0] make_key_code(input logic [KEY_INDEX_W-1:0] idx);
    return {8'h00, 2'b00, idx};
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Register-bus bundle between a host and the keypad scanner.
interface keypad_scanner_if;
  logic        cs;
  logic        read_enable;
  logic        write_enable;
  logic [2:0]  address;
  logic [15:0] write_data;
  logic [15:0] read_data_output;
  logic        irq;

  modport master (
    output cs, read_enable, write_enable, address, write_data,
    input  read_data_output, irq
  );

  modport slave (
    input  cs, read_enable, write_enable, address, write_data,
    output read_data_output, irq
  );
endinterface

// File: rtl/keypad_fifo.sv
// Key-code FIFO with synchronous flush; a push on a full FIFO succeeds only
// when a pop happens in the same cycle.
module keypad_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         push_data,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner with debounce, key-code FIFO and register interface.
// Define KEYPAD_SCANNER_IRQ_EN to enable the key-available interrupt.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int ROWS            = 4,
  parameter int COLS            = 4,
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int SETTLE_CYCLES   = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                clock,
  input  logic                reset,
  keypad_scanner_if.slave     bus,
  input  logic [COLS-1:0]     column,
  output logic [ROWS-1:0]     row
);
  localparam logic [31:0] DB_LAST     = 32'(DEBOUNCE_CYCLES - 1);
  localparam logic [31:0] SETTLE_LAST = 32'(SETTLE_CYCLES - 1);
  localparam logic [2:0]  LAST_ROW    = 3'(ROWS - 1);
  localparam int          CW          = $clog2(FIFO_DEPTH) + 1;

  state_t                  state;
  logic [31:0]             counter;
  logic [2:0]              row_idx;
  logic [ROWS-1:0]         row_q;
  logic                    push_valid;
  logic [KEY_CODE_W-1:0]   push_code;
  logic [2:0]              low_col;
  logic [KEY_INDEX_W-1:0]  key_index;
  logic                    any_low;

  logic                    rd_hit, wr_ctrl, pop, flush;
  logic                    overflow, irq_en;
  logic [KEY_CODE_W-1:0]   fifo_head;
  logic                    fifo_full, fifo_empty;
  logic [CW-1:0]           fifo_count;
  logic [15:0]             status;

  assign row     = row_q;
  assign any_low = (column != '1);

  // Descending walk so the lowest-numbered low column wins.
  always_comb begin
    low_col = '0;
    for (int c = COLS - 1; c >= 0; c--) begin
      if (!column[c]) low_col = 3'(c);
    end
  end

  assign key_index = KEY_INDEX_W'(32'(row_idx) * 32'(COLS) + 32'(low_col));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      counter    <= '0;
      row_idx    <= '0;
      row_q      <= '0;
      push_valid <= 1'b0;
      push_code  <= '0;
    end else begin
      push_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          row_q   <= '0;
          counter <= '0;
          row_idx <= '0;
          if (any_low) state <= DEBOUNCE;
        end
        DEBOUNCE: begin
          if (!any_low) begin
            state   <= IDLE;
            counter <= '0;
          end else if (counter == DB_LAST) begin
            state   <= SCAN;
            counter <= '0;
            row_idx <= '0;
            row_q   <= ~ROWS'(1);
          end else begin
            counter <= counter + 32'd1;
          end
        end
        SCAN: begin
          if (counter == SETTLE_LAST) begin
            counter <= '0;
            if (any_low) begin
              push_valid <= 1'b1;
              push_code  <= make_key_code(key_index);
              state      <= RELEASE;
              row_q      <= '0;
            end else if (row_idx == LAST_ROW) begin
              state <= IDLE;
              row_q <= '0;
            end else begin
              row_idx <= row_idx + 3'd1;
              row_q   <= ~(ROWS'(1) << (row_idx + 3'd1));
            end
          end else begin
            counter <= counter + 32'd1;
          end
        end
        RELEASE: begin
          row_q <= '0;
          if (any_low) begin
            counter <= '0;
          end else if (counter == DB_LAST) begin
            state   <= IDLE;
            counter <= '0;
          end else begin
            counter <= counter + 32'd1;
          end
        end
      endcase
    end
  end

  assign rd_hit  = bus.cs && bus.read_enable;
  assign wr_ctrl = bus.cs && bus.write_enable && (bus.address == ADDR_CTRL);
  assign pop     = rd_hit && (bus.address == ADDR_DATA) && !fifo_empty;
  assign flush   = wr_ctrl && bus.write_data[CTRL_FLUSH];

  keypad_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (KEY_CODE_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_valid),
    .pop       (pop),
    .flush     (flush),
    .push_data (push_code),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    status                        = '0;
    status[STAT_NONEMPTY]         = !fifo_empty;
    status[STAT_OVERFLOW]         = overflow;
    status[STAT_IRQ_EN]           = irq_en;
    status[STAT_COUNT_LSB +: 5]   = 5'(fifo_count);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.read_data_output <= '0;
      overflow             <= 1'b0;
    end else begin
      if (rd_hit) begin
        case (bus.address)
          ADDR_DATA:   bus.read_data_output <= fifo_empty ? 16'h0000 : fifo_head;
          ADDR_STATUS: bus.read_data_output <= status;
          default:     bus.read_data_output <= 16'h0000;
        endcase
      end
      // A push into a full FIFO is only lost when no pop frees a slot.
      if (flush) overflow <= 1'b0;
      else if (push_valid && fifo_full && !pop) overflow <= 1'b1;
    end
  end

`ifdef KEYPAD_SCANNER_IRQ_EN
  // irq_en is set-only; only reset clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      irq_en  <= 1'b0;
      bus.irq <= 1'b0;
    end else begin
      if (wr_ctrl && bus.write_data[CTRL_IRQ_EN]) irq_en <= 1'b1;
      bus.irq <= irq_en && !fifo_empty;
    end
  end
`else
  assign irq_en  = 1'b0;
  assign bus.irq = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed self-checking bench for keypad_scanner with a 4x4 key-matrix model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  logic        clock;
  logic        reset;
  logic [3:0]  column;
  logic [3:0]  row;
  logic [15:0] pressed;
  logic [15:0] rd;
  int          errors;
  int          checks;

  keypad_scanner_if bus();

  keypad_scanner #(
    .ROWS            (4),
    .COLS            (4),
    .DEBOUNCE_CYCLES (8),
    .SETTLE_CYCLES   (2),
    .FIFO_DEPTH      (4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .column (column),
    .row    (row)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // A pressed key pulls its column low whenever its row is driven low.
  always_comb begin
    column = '1;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && pressed[r*4 + c]) column[c] = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int cycles);
    @(negedge clock);
    pressed = keys;
    repeat (cycles) @(negedge clock);
  endtask

  task automatic busRead(input logic [2:0] addr, output logic [15:0] data);
    @(negedge clock);
    bus.cs = 1'b1;
    bus.read_enable = 1'b1;
    bus.address = addr;
    @(negedge clock);
    data = bus.read_data_output;
    bus.cs = 1'b0;
    bus.read_enable = 1'b0;
  endtask

  task automatic busWrite(input logic [2:0] addr, input logic [15:0] data, input logic sel);
    @(negedge clock);
    bus.cs = sel;
    bus.write_enable = 1'b1;
    bus.address = addr;
    bus.write_data = data;
    @(negedge clock);
    bus.cs = 1'b0;
    bus.write_enable = 1'b0;
    bus.write_data = '0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    pressed = '0;
    reset = 1'b1;
    bus.cs = 1'b0;
    bus.read_enable = 1'b0;
    bus.write_enable = 1'b0;
    bus.address = '0;
    bus.write_data = '0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    checkOutput("reset_row", 16'(row), 16'h0000);
    checkOutput("reset_rdo", bus.read_data_output, 16'h0000);
    checkOutput("reset_irq", 16'(bus.irq), 16'h0000);
    busRead(ADDR_STATUS, rd);
    checkOutput("reset_status", rd, 16'h0000);

    // Single key at row2/col1 -> index 9.
    applyStimulus(16'h0001 << 9, 40);
    checkOutput("hold_row_zero", 16'(row), 16'h0000);
    busRead(ADDR_STATUS, rd);
    checkOutput("hold_status", rd, 16'h0009);
    applyStimulus(16'h0000, 20);
    busRead(ADDR_STATUS, rd);
    checkOutput("one_code_only", rd, 16'h0009);
    busRead(ADDR_DATA, rd);
    checkOutput("read_key9", rd, 16'h0009);
    repeat (3) @(negedge clock);
    checkOutput("rdo_holds", bus.read_data_output, 16'h0009);
    busRead(ADDR_DATA, rd);
    checkOutput("read_empty", rd, 16'h0000);
    busRead(ADDR_STATUS, rd);
    checkOutput("status_after_pop", rd, 16'h0000);

    // Three-cycle glitch must not survive debounce.
    applyStimulus(16'h0001, 3);
    applyStimulus(16'h0000, 2);
    checkOutput("glitch_idle", 16'(dut.state), 16'(IDLE));
    repeat (20) @(negedge clock);
    busRead(ADDR_STATUS, rd);
    checkOutput("glitch_status", rd, 16'h0000);

    // Five presses into a depth-4 FIFO.
    applyStimulus(16'h0001 << 6, 30);  applyStimulus(16'h0000, 20);
    applyStimulus(16'h0001 << 5, 30);  applyStimulus(16'h0000, 20);
    applyStimulus(16'h0001 << 10, 30); applyStimulus(16'h0000, 20);
    applyStimulus(16'h0001 << 15, 30); applyStimulus(16'h0000, 20);
    applyStimulus(16'h0001 << 3, 30);  applyStimulus(16'h0000, 20);
    busRead(ADDR_STATUS, rd);
    checkOutput("overflow_status", rd, 16'h0023);
    busRead(3'd1, rd);
    checkOutput("odd_offset", rd, 16'h0000);
    busRead(ADDR_CTRL, rd);
    checkOutput("ctrl_read_zero", rd, 16'h0000);
    @(negedge clock);
    bus.cs = 1'b0;
    bus.read_enable = 1'b1;
    bus.address = ADDR_DATA;
    @(negedge clock);
    bus.read_enable = 1'b0;
    checkOutput("cs_low_read", bus.read_data_output, 16'h0000);
    busWrite(ADDR_CTRL, 16'h0001, 1'b0);
    busRead(ADDR_STATUS, rd);
    checkOutput("cs_low_no_effect", rd, 16'h0023);
    busRead(ADDR_DATA, rd);
    checkOutput("head_is_first", rd, 16'h0006);
    busRead(ADDR_STATUS, rd);
    checkOutput("status_after_pop3", rd, 16'h001B);
    busWrite(ADDR_CTRL, 16'h0001, 1'b1);
    busRead(ADDR_STATUS, rd);
    checkOutput("flush_status", rd, 16'h0000);

    // Two keys on row0 -> lowest column; keys on rows 1 and 3 -> first row scanned.
    applyStimulus(16'h000A, 30);
    applyStimulus(16'h0000, 20);
    busRead(ADDR_DATA, rd);
    checkOutput("lowest_col", rd, 16'h0001);
    applyStimulus((16'h0001 << 14) | (16'h0001 << 7), 30);
    applyStimulus(16'h0000, 20);
    busRead(ADDR_DATA, rd);
    checkOutput("first_row", rd, 16'h0007);

    // Reset during SCAN aborts the scan with no push.
    applyStimulus(16'h0001 << 13, 12);
    checkOutput("in_scan", 16'(dut.state), 16'(SCAN));
    reset = 1'b1;
    pressed = '0;
    #1;
    checkOutput("mid_reset_row", 16'(row), 16'h0000);
    checkOutput("mid_reset_rdo", bus.read_data_output, 16'h0000);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    busRead(ADDR_STATUS, rd);
    checkOutput("abort_no_push", rd, 16'h0000);

    // Interrupt behaviour depends on the build.
    busWrite(ADDR_CTRL, 16'h0002, 1'b1);
    applyStimulus(16'h0001 << 9, 30);
    applyStimulus(16'h0000, 20);
`ifdef KEYPAD_SCANNER_IRQ_EN
    checkOutput("irq_pending", 16'(bus.irq), 16'h0001);
    busRead(ADDR_STATUS, rd);
    checkOutput("irq_status", rd, 16'h000D);
`else
    checkOutput("irq_pending", 16'(bus.irq), 16'h0000);
    busRead(ADDR_STATUS, rd);
    checkOutput("irq_status", rd, 16'h0009);
`endif
    busRead(ADDR_DATA, rd);
    checkOutput("irq_pop", rd, 16'h0009);
    repeat (2) @(negedge clock);
    checkOutput("irq_cleared", 16'(bus.irq), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
